branch_predictor_gshare: RTL



---
 rtl/bp_pkg.sv | 32 +++
 rtl/bp_sat_counter_array.sv | 41 ++++
 rtl/branch_predictor_gshare.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/bp_pkg.sv
// Shared types and counter helpers for the gshare branch predictor.
// Struct fields use maximum widths; instances use the low DATA_WIDTH/TAG_BITS/CTR_BITS bits.
package bp_pkg;

  localparam int BP_MAX_DATA_W = 64;
  localparam int BP_MAX_TAG_W  = 32;
  localparam int BP_MAX_CTR_W  = 8;

  typedef logic [BP_MAX_CTR_W-1:0] ctr_t;

  typedef struct packed {
    logic                     valid;
    logic                     jump;
    logic [BP_MAX_TAG_W-1:0]  tag;
    logic [BP_MAX_DATA_W-1:0] target;
  } btb_entry_t;

  // Weakly-not-taken value: just below the taken threshold.
  function automatic ctr_t weak_nt(input int ctr_bits);
    return ctr_t'((1 << (ctr_bits - 1)) - 1);
  endfunction

  function automatic ctr_t sat_update(input ctr_t ctr, input logic taken, input int ctr_bits);
    ctr_t max_v;
    max_v = ctr_t'((1 << ctr_bits) - 1);
    if (taken) begin
      return (ctr == max_v) ? ctr : ctr + ctr_t'(1);
    end
    return (ctr == '0) ? ctr : ctr - ctr_t'(1);
  endfunction

endpackage

// File: rtl/bp_sat_counter_array.sv
// Pattern history table: array of saturating counters with one async read port
// and one registered update port; reset loads every counter to weakly-not-taken.
module bp_sat_counter_array
  import bp_pkg::*;
#(
  parameter int ENTRIES  = 256,
  parameter int CTR_BITS = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [$clog2(ENTRIES)-1:0] rd_idx,
  output logic [CTR_BITS-1:0]        rd_ctr,
  input  logic                       wr_en,
  input  logic [$clog2(ENTRIES)-1:0] wr_idx,
  input  logic                       wr_taken
);

  logic [CTR_BITS-1:0] ctr_q [ENTRIES];
  logic [CTR_BITS-1:0] ctr_d [ENTRIES];

  assign rd_ctr = ctr_q[rd_idx];

  always_comb begin
    ctr_d = ctr_q;
    if (wr_en) begin
      ctr_d[wr_idx] = CTR_BITS'(sat_update(ctr_t'(ctr_q[wr_idx]), wr_taken, CTR_BITS));
    end
  end

  // Reset overrides any same-cycle update.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= CTR_BITS'(weak_nt(CTR_BITS));
      end
    end else begin
      ctr_q <= ctr_d;
    end
  end

endmodule

// File: rtl/branch_predictor_gshare.sv
// Gshare branch predictor: tagged BTB with jump flag, GHR, PHT indexed by PC^GHR.
// Optional BP_PERF_CNT_EN adds saturating branch/mispredict counters.
module branch_predictor_gshare
  import bp_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int BTB_ENTRIES = 64,
  parameter int PHT_ENTRIES = 256,
  parameter int GHR_BITS    = 8,
  parameter int TAG_BITS    = 16,
  parameter int CTR_BITS    = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DATA_WIDTH-1:0]          PCF,
  output logic                           PredictTakenF,
  output logic [DATA_WIDTH-1:0]          PredictedTargetF,
  output logic [$clog2(PHT_ENTRIES)-1:0] PhtIdxF,
  input  logic [DATA_WIDTH-1:0]          PCE,
  input  logic [DATA_WIDTH-1:0]          PCTargetE,
  input  logic                           BranchE,
  input  logic                           JumpE,
  input  logic                           BranchTakenE,
  input  logic [$clog2(PHT_ENTRIES)-1:0] PhtIdxE,
  input  logic                           MispredictE
`ifdef BP_PERF_CNT_EN
  ,
  output logic [31:0]                    BranchCountO,
  output logic [31:0]                    MispredictCountO
`endif
);

  localparam int BTB_IDX_W = $clog2(BTB_ENTRIES);
  localparam int PHT_IDX_W = $clog2(PHT_ENTRIES);

  btb_entry_t            btb_q [BTB_ENTRIES];
  btb_entry_t            btb_d [BTB_ENTRIES];
  logic [GHR_BITS-1:0]   ghr_q;
  logic [GHR_BITS-1:0]   ghr_d;

  logic [BTB_IDX_W-1:0]  btb_idx_f;
  logic [TAG_BITS-1:0]   tag_f;
  logic [PHT_IDX_W-1:0]  pht_idx_f;
  logic [CTR_BITS-1:0]   pht_ctr_f;
  logic                  hit_f;
  logic                  taken_f;
  logic [BTB_IDX_W-1:0]  btb_idx_e;
  logic [TAG_BITS-1:0]   tag_e;
  logic                  upd_e;
  logic                  unused_bits;

  // Fetch stage: combinational lookup against registered tables
  assign btb_idx_f = PCF[BTB_IDX_W+1:2];
  assign tag_f     = PCF[BTB_IDX_W+2 +: TAG_BITS];
  assign pht_idx_f = PCF[PHT_IDX_W+1:2] ^ PHT_IDX_W'(ghr_q);

  bp_sat_counter_array #(
    .ENTRIES  (PHT_ENTRIES),
    .CTR_BITS (CTR_BITS)
  ) u_pht (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (pht_idx_f),
    .rd_ctr   (pht_ctr_f),
    .wr_en    (BranchE),
    .wr_idx   (PhtIdxE),
    .wr_taken (BranchTakenE)
  );

  assign hit_f   = btb_q[btb_idx_f].valid && (btb_q[btb_idx_f].tag == BP_MAX_TAG_W'(tag_f));
  assign taken_f = !rst && hit_f && (btb_q[btb_idx_f].jump || pht_ctr_f[CTR_BITS-1]);

  assign PredictTakenF    = taken_f;
  assign PredictedTargetF = taken_f ? btb_q[btb_idx_f].target[DATA_WIDTH-1:0]
                                    : PCF + DATA_WIDTH'(4);
  assign PhtIdxF          = pht_idx_f;

  // Execute stage: train BTB and GHR on the next edge
  assign btb_idx_e = PCE[BTB_IDX_W+1:2];
  assign tag_e     = PCE[BTB_IDX_W+2 +: TAG_BITS];
  assign upd_e     = BranchE || JumpE;

  always_comb begin
    btb_d = btb_q;
    if (upd_e) begin
      btb_d[btb_idx_e].valid  = 1'b1;
      btb_d[btb_idx_e].jump   = JumpE;
      btb_d[btb_idx_e].tag    = BP_MAX_TAG_W'(tag_e);
      btb_d[btb_idx_e].target = BP_MAX_DATA_W'(PCTargetE);
    end
  end

  always_comb begin
    ghr_d = ghr_q;
    if (BranchE) begin
      ghr_d = {ghr_q[GHR_BITS-2:0], BranchTakenE};
    end
  end

  // Only valid bits are reset; tag/target are don't-care while invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      ghr_q <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_q[i].valid <= 1'b0;
      end
    end else begin
      ghr_q <= ghr_d;
      btb_q <= btb_d;
    end
  end

`ifdef BP_PERF_CNT_EN
  logic [31:0] branch_cnt_q;
  logic [31:0] branch_cnt_d;
  logic [31:0] mispred_cnt_q;
  logic [31:0] mispred_cnt_d;

  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (upd_e && !(&branch_cnt_q)) begin
      branch_cnt_d = branch_cnt_q + 32'd1;
    end
    if (MispredictE && !(&mispred_cnt_q)) begin
      mispred_cnt_d = mispred_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign BranchCountO     = branch_cnt_q;
  assign MispredictCountO = mispred_cnt_q;
  assign unused_bits      = ^{PCF, PCE};
`else
  assign unused_bits      = ^{PCF, PCE, MispredictE};
`endif

  // A conditional branch cannot also be a jump.
  a_branch_xor_jump: assert property (@(posedge clk) disable iff (rst) !(BranchE && JumpE));

endmodule
